matching_engine: RTL and testbench
==================================

# matching_engine

Single-level limit-order matching stage between the Order Generator and the Spread Calculator. Accepts one order at a time over a valid/ready handshake and holds at most one resting order per side, the best bid and the best ask. It crosses each incoming order against the opposite side and emits a one-cycle `match_flag` with the matched buy/sell limit prices for the Spread Calculator, plus book state for display.

## Interface
- `QTY_W`, default 4: quantity width; quantities saturate at 2^QTY_W−1.
- `CNT_W`, default 16: match counter width.
- `clk` input 1: system clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `enable` input 1: from FSM Controller; gates acceptance of new orders.
- `order_valid` input 1: order present.
- `order_ready` output 1: engine can accept; high only in IDLE with `enable`=1.
- `order_side` input 1: 0 = buy, 1 = sell.
- `order_price` input 8: limit price, unsigned.
- `order_qty` input QTY_W: quantity; 0 is rejected.
- `match_flag` output 1: one-cycle pulse per trade.
- `buy_price` / `sell_price` output 8: bid / ask limit prices of the trade; valid while `match_flag`=1, held otherwise.
- `match_qty` output QTY_W: traded quantity; valid with `match_flag`.
- `reject_flag` output 1: one-cycle pulse when an order (or residual) is dropped.
- `best_bid`, `best_ask` output 8; `bid_qty`, `ask_qty` output QTY_W; `bid_valid`, `ask_valid` output 1: resting book.
- `match_count` output CNT_W: total trades, wraps.

## Operation
- States: IDLE, EVAL, MATCH, BOOK.
- IDLE: `order_ready`=`enable`. On `order_valid && order_ready`, capture side/price/qty into the incoming register, go to EVAL.
- EVAL: compute crossing. A buy crosses when `ask_valid && price >= best_ask`; a sell crosses when `bid_valid && price <= best_bid`. Cross goes to MATCH. No cross goes to BOOK.
- MATCH: `match_flag`=1, with `match_qty` = min(incoming qty, resting qty). For a buy, `buy_price` = incoming price and `sell_price` = `best_ask`. For a sell, `buy_price` = `best_bid` and `sell_price` = incoming price. So `buy_price >= sell_price` always holds.
  - On exit, subtract `match_qty` from both quantities. The resting side clears its valid bit when its quantity reaches 0. `match_count` increments.
  - Incoming residual > 0 goes to BOOK. Otherwise go to IDLE.
- BOOK, for the incoming order or its residual:
  - Same side empty: rest it.
  - Strictly better price (higher bid / lower ask): replace the resting order.
  - Equal price: add quantities, saturating.
  - Worse price, or qty 0: drop it and pulse `reject_flag`.
  - Always go to IDLE.
- One trade per order at most; a residual never re-crosses, because it goes straight to BOOK.
- `enable` low does not abort an order in flight; it only blocks acceptance in IDLE.
- Reset values: state IDLE, all outputs 0, both valid bits 0, counter 0.

## Timing
- Accept edge E0. EVAL occupies the cycle E0–E1. MATCH or BOOK occupies E1–E2.
- `match_flag`, `buy_price`, `sell_price` and `match_qty` are registered and change at E1, so the Spread Calculator samples them at E2.
- Book and counter update at E2. A residual BOOK cycle runs E2–E3, with the book updated at E3.
- Throughput:
  - No residual: 3 cycles per order.
  - With residual: 4 cycles per order.
  - `order_ready` is low from E0 until the state returns to IDLE.
- `match_flag` and `reject_flag` are never high in the same cycle; each is high for exactly one cycle.
- Asynchronous reset asserted mid-order discards the in-flight order and pulses nothing. The first accept is possible on the first edge after release.

## Structure
- Shared package `mkt_pkg`: state enum, `PRICE_W`=8, side encodings `SIDE_BUY`/`SIDE_SELL`, and a `book_entry_t` {valid, price, qty} typedef.
- One sub-module, `book_side`, instantiated twice (bid/ask). It holds one entry and takes rest/replace/merge/consume commands, with an `is_bid` parameter selecting the "better price" comparison direction.

## Test plan
- Reset, then buy 100×5: no match, bid = 100/5, `bid_valid`=1, accept→book 3 cycles, `match_flag` never high.
- Book bid 100×5, then sell 98×3: `match_flag` one cycle with buy 100, sell 98, qty 3. Bid becomes 100×2, `match_count`=1.
- Book ask 90×2, then buy 95×6: match with qty 2 (buy 95 / sell 90). Ask becomes empty and the residual buy 95×4 rests as the bid. Total 4 cycles.
- Book bid 100×5, then buy 99×1: `reject_flag` pulse, bid unchanged. Then buy 100×15: qty saturates at 15.
- `enable`=0 with `order_valid`=1: `order_ready`=0 and nothing accepted. Raise `enable`: accept on the next edge.
- Assert reset during MATCH: all outputs and book return to 0, no pulse. The next order behaves as from a clean reset.

Source files
------------

// File: rtl/mkt_pkg.sv
// Shared types and constants for the single-level matching engine.
package mkt_pkg;

  localparam int PRICE_W   = 8;
  localparam int MAX_QTY_W = 16;

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_MATCH,
    ST_BOOK
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_REST,
    CMD_REPLACE,
    CMD_MERGE,
    CMD_CONSUME
  } book_cmd_t;

  // qty is sized for the widest supported quantity; users cast to their QTY_W.
  typedef struct packed {
    logic                 valid;
    logic [PRICE_W-1:0]   price;
    logic [MAX_QTY_W-1:0] qty;
  } book_entry_t;

endpackage

// File: rtl/book_side.sv
// One side of the book: a single resting order with rest/replace/merge/consume
// commands and a price comparator whose direction depends on is_bid.
module book_side
  import mkt_pkg::*;
#(
  parameter int QTY_W  = 4,
  parameter bit is_bid = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  book_cmd_t           cmd,
  input  logic [PRICE_W-1:0]  cmd_price,
  input  logic [QTY_W-1:0]    cmd_qty,
  input  logic [PRICE_W-1:0]  cand_price,
  output logic                cand_better,
  output logic                cand_equal,
  output logic                valid,
  output logic [PRICE_W-1:0]  price,
  output logic [QTY_W-1:0]    qty
);

  book_entry_t      entry_q;
  logic [QTY_W:0]   sum;
  logic [QTY_W-1:0] merged;
  logic [QTY_W-1:0] remain;

  assign valid  = entry_q.valid;
  assign price  = entry_q.price;
  assign qty    = QTY_W'(entry_q.qty);

  assign sum    = {1'b0, qty} + {1'b0, cmd_qty};
  assign merged = sum[QTY_W] ? {QTY_W{1'b1}} : sum[QTY_W-1:0];
  assign remain = qty - cmd_qty;

  // Higher is better for a bid, lower is better for an ask.
  assign cand_better = is_bid ? (cand_price > price) : (cand_price < price);
  assign cand_equal  = (cand_price == price);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q <= '0;
    end else begin
      case (cmd)
        CMD_REST, CMD_REPLACE: begin
          entry_q.valid <= 1'b1;
          entry_q.price <= cmd_price;
          entry_q.qty   <= MAX_QTY_W'(cmd_qty);
        end
        CMD_MERGE: entry_q.qty <= MAX_QTY_W'(merged);
        CMD_CONSUME: begin
          entry_q.qty <= MAX_QTY_W'(remain);
          if (remain == '0) entry_q.valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/matching_engine.sv
// Single-level limit-order matcher: one resting order per side, at most one
// trade per incoming order, residual goes straight to the book.
module matching_engine
  import mkt_pkg::*;
#(
  parameter int QTY_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               order_valid,
  output logic               order_ready,
  input  logic               order_side,
  input  logic [PRICE_W-1:0] order_price,
  input  logic [QTY_W-1:0]   order_qty,
  output logic               match_flag,
  output logic [PRICE_W-1:0] buy_price,
  output logic [PRICE_W-1:0] sell_price,
  output logic [QTY_W-1:0]   match_qty,
  output logic               reject_flag,
  output logic [PRICE_W-1:0] best_bid,
  output logic [PRICE_W-1:0] best_ask,
  output logic [QTY_W-1:0]   bid_qty,
  output logic [QTY_W-1:0]   ask_qty,
  output logic               bid_valid,
  output logic               ask_valid,
  output logic [CNT_W-1:0]   match_count
);

  state_t             state;
  logic               inc_side;
  logic [PRICE_W-1:0] inc_price;
  logic [QTY_W-1:0]   inc_qty;

  book_cmd_t          bid_cmd;
  book_cmd_t          ask_cmd;
  logic [QTY_W-1:0]   book_cmd_qty;
  logic               bid_better, bid_equal, ask_better, ask_equal;

  logic               is_buy;
  logic               crosses;
  logic [QTY_W-1:0]   rest_qty;
  logic [QTY_W-1:0]   trade_qty;
  logic [QTY_W-1:0]   residual;
  logic               same_valid, same_better, same_equal;
  logic               price_worse;
  book_cmd_t          place_cmd;

  assign order_ready = (state == ST_IDLE) && enable;

  assign is_buy    = (inc_side == SIDE_BUY);
  assign crosses   = is_buy ? (ask_valid && inc_price >= best_ask)
                            : (bid_valid && inc_price <= best_bid);
  assign rest_qty  = is_buy ? ask_qty : bid_qty;
  assign trade_qty = (inc_qty < rest_qty) ? inc_qty : rest_qty;
  assign residual  = inc_qty - match_qty;

  // Same-side view used when placing the incoming order or its residual.
  assign same_valid  = is_buy ? bid_valid  : ask_valid;
  assign same_better = is_buy ? bid_better : ask_better;
  assign same_equal  = is_buy ? bid_equal  : ask_equal;
  assign price_worse = same_valid && !same_better && !same_equal;

  // NOTE: every variable in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    bid_cmd      = CMD_NONE;
    ask_cmd      = CMD_NONE;
    book_cmd_qty = inc_qty;
    place_cmd    = CMD_NONE;
    if (!same_valid)     place_cmd = CMD_REST;
    else if (same_better) place_cmd = CMD_REPLACE;
    else if (same_equal)  place_cmd = CMD_MERGE;

    if (state == ST_MATCH) begin
      book_cmd_qty = match_qty;
      if (is_buy) ask_cmd = CMD_CONSUME;
      else        bid_cmd = CMD_CONSUME;
    end else if (state == ST_BOOK && inc_qty != '0) begin
      if (is_buy) bid_cmd = place_cmd;
      else        ask_cmd = place_cmd;
    end
  end

  book_side #(.QTY_W(QTY_W), .is_bid(1'b1)) u_bid (
    .clk         (clk),
    .reset       (reset),
    .cmd         (bid_cmd),
    .cmd_price   (inc_price),
    .cmd_qty     (book_cmd_qty),
    .cand_price  (inc_price),
    .cand_better (bid_better),
    .cand_equal  (bid_equal),
    .valid       (bid_valid),
    .price       (best_bid),
    .qty         (bid_qty)
  );

  book_side #(.QTY_W(QTY_W), .is_bid(1'b0)) u_ask (
    .clk         (clk),
    .reset       (reset),
    .cmd         (ask_cmd),
    .cmd_price   (inc_price),
    .cmd_qty     (book_cmd_qty),
    .cand_price  (inc_price),
    .cand_better (ask_better),
    .cand_equal  (ask_equal),
    .valid       (ask_valid),
    .price       (best_ask),
    .qty         (ask_qty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      inc_side    <= SIDE_BUY;
      inc_price   <= '0;
      inc_qty     <= '0;
      match_flag  <= 1'b0;
      buy_price   <= '0;
      sell_price  <= '0;
      match_qty   <= '0;
      reject_flag <= 1'b0;
      match_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (order_valid && order_ready) begin
            inc_side  <= order_side;
            inc_price <= order_price;
            inc_qty   <= order_qty;
            state     <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          // A zero-quantity order never trades; it falls through to a reject.
          if (inc_qty != '0 && crosses) begin
            match_flag <= 1'b1;
            match_qty  <= trade_qty;
            buy_price  <= is_buy ? inc_price : best_bid;
            sell_price <= is_buy ? best_ask  : inc_price;
            state      <= ST_MATCH;
          end else begin
            reject_flag <= (inc_qty == '0) || price_worse;
            state       <= ST_BOOK;
          end
        end
        ST_MATCH: begin
          match_flag  <= 1'b0;
          inc_qty     <= residual;
          match_count <= match_count + 1'b1;
          if (residual != '0) begin
            reject_flag <= price_worse;
            state       <= ST_BOOK;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BOOK: begin
          reject_flag <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matching_engine.sv
// Scenario bench for matching_engine: expected trades are queued before each
// order and popped as match_flag pulses are observed.
module tb_matching_engine;

  localparam int QTY_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b1;
  logic             order_valid = 1'b0;
  logic             order_ready;
  logic             order_side = 1'b0;
  logic [7:0]       order_price = '0;
  logic [QTY_W-1:0] order_qty = '0;
  logic             match_flag;
  logic [7:0]       buy_price, sell_price;
  logic [QTY_W-1:0] match_qty;
  logic             reject_flag;
  logic [7:0]       best_bid, best_ask;
  logic [QTY_W-1:0] bid_qty, ask_qty;
  logic             bid_valid, ask_valid;
  logic [CNT_W-1:0] match_count;

  typedef struct {
    logic [7:0]       buy;
    logic [7:0]       sell;
    logic [QTY_W-1:0] qty;
  } match_t;

  match_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     match_seen = 0;
  int     reject_seen = 0;

  matching_engine #(.QTY_W(QTY_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .order_valid (order_valid),
    .order_ready (order_ready),
    .order_side  (order_side),
    .order_price (order_price),
    .order_qty   (order_qty),
    .match_flag  (match_flag),
    .buy_price   (buy_price),
    .sell_price  (sell_price),
    .match_qty   (match_qty),
    .reject_flag (reject_flag),
    .best_bid    (best_bid),
    .best_ask    (best_ask),
    .bid_qty     (bid_qty),
    .ask_qty     (ask_qty),
    .bid_valid   (bid_valid),
    .ask_valid   (ask_valid),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  // Every wait goes through here so pulses are monitored on each falling edge.
  task automatic tick();
    match_t e;
    @(negedge clk);
    if (match_flag) begin
      match_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_match got buy=%0d sell=%0d qty=%0d required none",
                 buy_price, sell_price, match_qty);
      end else begin
        e = exp_q.pop_front();
        if (buy_price !== e.buy || sell_price !== e.sell || match_qty !== e.qty) begin
          errors++;
          $display("FAIL match_data got buy=%0d sell=%0d qty=%0d required buy=%0d sell=%0d qty=%0d",
                   buy_price, sell_price, match_qty, e.buy, e.sell, e.qty);
        end
      end
      if (reject_flag) begin
        errors++;
        $display("FAIL flags_overlap got match=1 reject=1 required not both");
      end
    end
    if (reject_flag) reject_seen++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    order_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic send_order(input logic side, input logic [7:0] price,
                            input logic [QTY_W-1:0] qty, output int cycles);
    bit accepted = 0;
    bit done = 0;
    order_side  = side;
    order_price = price;
    order_qty   = qty;
    order_valid = 1'b1;
    cycles = 0;
    #1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (order_ready) accepted = 1;
      else tick();
    end
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL accept_timeout got ready=0 required ready=1");
      order_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 order_valid = 1'b0;
    cycles = 1;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (order_ready) done = 1;
      else cycles++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL idle_timeout got ready=0 required ready=1");
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if ({match_flag, reject_flag, bid_valid, ask_valid, match_count, buy_price, sell_price,
         match_qty, best_bid, best_ask, bid_qty, ask_qty} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero required all zero");
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_book_buy();
    int cyc;
    send_order(1'b0, 8'd100, 4'd5, cyc);
    check_int("book_cycles", cyc, 3);
    check_int("book_bid", {bid_valid, best_bid, bid_qty}, {1'b1, 8'd100, 4'd5});
    check_int("book_ask_empty", ask_valid, 0);
    check_int("book_no_match", match_seen, 0);
  endtask

  task automatic test_partial_match();
    int cyc;
    exp_q.push_back('{buy: 8'd100, sell: 8'd98, qty: 4'd3});
    send_order(1'b1, 8'd98, 4'd3, cyc);
    check_int("partial_cycles", cyc, 3);
    check_int("partial_pending", exp_q.size(), 0);
    check_int("partial_bid", {bid_valid, best_bid, bid_qty}, {1'b1, 8'd100, 4'd2});
    check_int("partial_count", match_count, 1);
    check_int("partial_ask_empty", ask_valid, 0);
  endtask

  task automatic test_residual();
    int cyc;
    do_reset();
    send_order(1'b1, 8'd90, 4'd2, cyc);
    check_int("res_ask_booked", {ask_valid, best_ask, ask_qty}, {1'b1, 8'd90, 4'd2});
    exp_q.push_back('{buy: 8'd95, sell: 8'd90, qty: 4'd2});
    send_order(1'b0, 8'd95, 4'd6, cyc);
    check_int("res_cycles", cyc, 4);
    check_int("res_pending", exp_q.size(), 0);
    check_int("res_ask_empty", {ask_valid, ask_qty}, 0);
    check_int("res_bid", {bid_valid, best_bid, bid_qty}, {1'b1, 8'd95, 4'd4});
    check_int("res_count", match_count, 1);
  endtask

  task automatic test_reject_saturate();
    int cyc;
    int rej0;
    do_reset();
    send_order(1'b0, 8'd100, 4'd5, cyc);
    rej0 = reject_seen;
    send_order(1'b0, 8'd99, 4'd1, cyc);
    check_int("worse_reject", reject_seen - rej0, 1);
    check_int("worse_bid_kept", {bid_valid, best_bid, bid_qty}, {1'b1, 8'd100, 4'd5});
    send_order(1'b0, 8'd100, 4'd15, cyc);
    check_int("merge_saturate", {best_bid, bid_qty}, {8'd100, 4'd15});
    send_order(1'b0, 8'd101, 4'd2, cyc);
    check_int("better_replace", {best_bid, bid_qty}, {8'd101, 4'd2});
    send_order(1'b0, 8'd150, 4'd0, cyc);
    check_int("zero_qty_reject", reject_seen - rej0, 2);
    check_int("zero_qty_bid_kept", {best_bid, bid_qty}, {8'd101, 4'd2});
  endtask

  task automatic test_equal_cross();
    int cyc;
    int m0 = match_seen;
    exp_q.push_back('{buy: 8'd101, sell: 8'd101, qty: 4'd2});
    send_order(1'b1, 8'd101, 4'd7, cyc);
    check_int("eq_cycles", cyc, 4);
    check_int("eq_one_trade", match_seen - m0, 1);
    check_int("eq_bid_empty", bid_valid, 0);
    check_int("eq_ask", {ask_valid, best_ask, ask_qty}, {1'b1, 8'd101, 4'd5});
    check_int("eq_count", match_count, 1);
  endtask

  task automatic test_enable();
    int cyc;
    enable = 1'b0;
    order_side = 1'b0; order_price = 8'd10; order_qty = 4'd1;
    order_valid = 1'b1;
    repeat (5) tick();
    check_int("disabled_ready", order_ready, 0);
    check_int("disabled_bid", bid_valid, 0);
    enable = 1'b1;
    #1;
    check_int("enabled_ready", order_ready, 1);
    @(posedge clk);
    #1 order_valid = 1'b0;
    check_int("accepted_ready_low", order_ready, 0);
    repeat (3) tick();
    check_int("enabled_bid", {bid_valid, best_bid, bid_qty}, {1'b1, 8'd10, 4'd1});
  endtask

  task automatic test_reset_mid();
    int cyc;
    int m0 = match_seen;
    int r0 = reject_seen;
    order_side = 1'b0; order_price = 8'd101; order_qty = 4'd1;
    order_valid = 1'b1;
    @(posedge clk);
    #1 order_valid = 1'b0;
    tick();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_int("midreset_flags", {match_flag, reject_flag}, 0);
    check_int("midreset_book", {bid_valid, ask_valid, best_bid, best_ask, bid_qty, ask_qty}, 0);
    check_int("midreset_out", {match_count, buy_price, sell_price, match_qty}, 0);
    tick();
    reset = 1'b1;
    tick();
    check_int("midreset_no_pulse", (match_seen - m0) + (reject_seen - r0), 0);
    send_order(1'b0, 8'd100, 4'd5, cyc);
    check_int("post_reset_cycles", cyc, 3);
    check_int("post_reset_bid", {bid_valid, best_bid, bid_qty}, {1'b1, 8'd100, 4'd5});
    check_int("post_reset_clean", {ask_valid, match_count}, 0);
  endtask

  initial begin
    test_reset();
    test_book_buy();
    test_partial_match();
    test_residual();
    test_reject_saturate();
    test_equal_cross();
    test_enable();
    test_reset_mid();
    check_int("leftover_expected", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
